// File: rtl/can_rx_read_ctrl.sv
// CAN RX read sequencer: pops one 128-bit message from the RX FIFO into a holding
// register and serves it to the host as ID/DLC/DW1/DW2 words until DW2 is read.
module can_rx_read_ctrl #(
    parameter int FIFO_RD_LAT = 1,
    parameter int CNT_W       = 16
) (
    input  logic             sys_clk,
    input  logic             IP2Can_reset,
    input  logic             rxfifo_empty,
    output logic             rxfifo_rd_en,
    input  logic [127:0]     rxfifo_op,
    input  logic             host_rd_req,
    input  logic [1:0]       host_rd_addr,
    output logic [31:0]      host_rd_data,
    output logic             host_rd_ack,
    output logic             msg_valid,
    output logic             rd_underrun,
    output logic [CNT_W-1:0] rx_msg_cnt
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

    localparam logic [1:0] LAT = 2'(FIFO_RD_LAT);

    state_t             state_q;
    logic [1:0]         lat_cnt_q;
    logic [127:0]       hold_q;
    logic               rd_en_q;
    logic               ack_q;
    logic [31:0]        data_q;
    logic               msg_valid_q;
    logic               underrun_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        word_d;
    logic               consume;

    always_comb begin
        word_d = hold_q[127:96];
        case (host_rd_addr)
            2'd0:    word_d = hold_q[127:96];
            2'd1:    word_d = hold_q[95:64];
            2'd2:    word_d = hold_q[63:32];
            default: word_d = hold_q[31:0];
        endcase
    end

    // msg_valid_q is high exactly while in HOLD, so it doubles as the HOLD qualifier
    assign consume = host_rd_req && (host_rd_addr == 2'd3) && msg_valid_q;

    always_ff @(posedge sys_clk) begin
        if (IP2Can_reset) begin
            state_q     <= IDLE;
            lat_cnt_q   <= 2'd0;
            hold_q      <= '0;
            rd_en_q     <= 1'b0;
            ack_q       <= 1'b0;
            data_q      <= '0;
            msg_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            rd_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rxfifo_empty) begin
                        state_q <= FETCH;
                        rd_en_q <= 1'b1;
                    end
                end
                FETCH: begin
                    state_q   <= WAIT;
                    lat_cnt_q <= 2'd1;
                end
                WAIT: begin
                    // FETCH is latency cycle zero; data lands on the LAT-th WAIT cycle
                    if (lat_cnt_q == LAT) begin
                        hold_q      <= rxfifo_op;
                        msg_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 2'd1;
                    end
                end
                HOLD: begin
                    if (consume) begin
                        state_q     <= IDLE;
                        msg_valid_q <= 1'b0;
                        cnt_q       <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase

            ack_q  <= host_rd_req;
            data_q <= (host_rd_req && msg_valid_q) ? word_d : 32'd0;
            if (host_rd_req && !msg_valid_q)
                underrun_q <= 1'b1;
        end
    end

    assign rxfifo_rd_en = rd_en_q;
    assign host_rd_ack  = ack_q;
    assign host_rd_data = data_q;
    assign msg_valid    = msg_valid_q;
    assign rd_underrun  = underrun_q;
    assign rx_msg_cnt   = cnt_q;

endmodule

// File: tb/tb_can_rx_read_ctrl.sv
// Directed bench for can_rx_read_ctrl: main instance (L=1) fed by a FIFO model,
// a CNT_W=2 instance for counter wrap, and an L=3 instance for reset mid-fetch.
module tb_can_rx_read_ctrl;

    logic sys_clk;
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic rst, rst2;

    logic         empty0 = 1'b1, rd_en0, req0, ack0, mv0, ur0;
    logic [127:0] op0 = '0;
    logic [1:0]   addr0;
    logic [31:0]  data0;
    logic [15:0]  cnt0;

    logic         empty1, rd_en1, req1, ack1, mv1, ur1;
    logic [127:0] op1;
    logic [1:0]   addr1;
    logic [31:0]  data1;
    logic [1:0]   cnt1;

    logic         empty2, rd_en2, req2, ack2, mv2, ur2;
    logic [127:0] op2;
    logic [1:0]   addr2;
    logic [31:0]  data2;
    logic [15:0]  cnt2;

    can_rx_read_ctrl #(.FIFO_RD_LAT(1), .CNT_W(16)) u0 (
        .sys_clk(sys_clk), .IP2Can_reset(rst), .rxfifo_empty(empty0), .rxfifo_rd_en(rd_en0),
        .rxfifo_op(op0), .host_rd_req(req0), .host_rd_addr(addr0), .host_rd_data(data0),
        .host_rd_ack(ack0), .msg_valid(mv0), .rd_underrun(ur0), .rx_msg_cnt(cnt0));

    can_rx_read_ctrl #(.FIFO_RD_LAT(1), .CNT_W(2)) u1 (
        .sys_clk(sys_clk), .IP2Can_reset(rst), .rxfifo_empty(empty1), .rxfifo_rd_en(rd_en1),
        .rxfifo_op(op1), .host_rd_req(req1), .host_rd_addr(addr1), .host_rd_data(data1),
        .host_rd_ack(ack1), .msg_valid(mv1), .rd_underrun(ur1), .rx_msg_cnt(cnt1));

    can_rx_read_ctrl #(.FIFO_RD_LAT(3), .CNT_W(16)) u2 (
        .sys_clk(sys_clk), .IP2Can_reset(rst2), .rxfifo_empty(empty2), .rxfifo_rd_en(rd_en2),
        .rxfifo_op(op2), .host_rd_req(req2), .host_rd_addr(addr2), .host_rd_data(data2),
        .host_rd_ack(ack2), .msg_valid(mv2), .rd_underrun(ur2), .rx_msg_cnt(cnt2));

    // FIFO model for u0: one-cycle read latency, registered empty flag
    logic [127:0] fq[$];
    logic         push_v;
    logic [127:0] push_d;
    always @(posedge sys_clk) begin
        if (push_v) fq.push_back(push_d);
        if (rd_en0 && fq.size() > 0) op0 <= fq.pop_front();
        empty0 <= (fq.size() == 0);
    end

    // Pop log for u0
    int cyc = 0;
    int pops = 0;
    int pop_cyc[8];
    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (rd_en0 && pops < 8) begin
            pop_cyc[pops] <= cyc;
            pops <= pops + 1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic sel_mv(input int which);
        return (which == 0) ? mv0 : ((which == 1) ? mv1 : mv2);
    endfunction

    task automatic wait_mv(input int which, input string tag);
        int k;
        logic v;
        k = 0;
        v = sel_mv(which);
        while (!v && k < 20) begin
            tick();
            k++;
            v = sel_mv(which);
        end
        chk(tag, 32'(v), 32'd1);
    endtask

    localparam logic [127:0] M1 = {32'h0000_0123, 32'h0000_0008, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    localparam logic [127:0] M2 = {32'h0000_0ABC, 32'h0000_0004, 32'h1111_2222, 32'h3333_4444};
    localparam logic [127:0] JK = {4{32'hEEEE_EEEE}};
    localparam logic [127:0] MR = {32'h0000_0BAD, 32'h0000_0001, 32'h0BAD_0BAD, 32'h0BAD_F00D};
    localparam logic [127:0] MX = {32'h0000_0777, 32'h0000_0002, 32'h1234_5678, 32'h8765_4321};

    logic [127:0] mb[3];
    logic [31:0]  mb_dw2[3];

    initial begin
        mb[0] = {32'h10, 32'h8, 32'hA000_0000, 32'hB000_0000};
        mb[1] = {32'h11, 32'h8, 32'hA000_0001, 32'hB000_0001};
        mb[2] = {32'h12, 32'h8, 32'hA000_0002, 32'hB000_0002};
        mb_dw2[0] = 32'hB000_0000;
        mb_dw2[1] = 32'hB000_0001;
        mb_dw2[2] = 32'hB000_0002;

        rst = 1'b1; rst2 = 1'b1;
        push_v = 1'b1; push_d = M1;
        req0 = 1'b1; addr0 = 2'd0;
        req1 = 1'b0; addr1 = 2'd0; empty1 = 1'b0;
        op1 = {32'h7, 32'h1, 32'h55, 32'h99};
        req2 = 1'b0; addr2 = 2'd0; empty2 = 1'b1; op2 = JK;

        // Reset held two cycles with FIFO non-empty and a request pending
        tick();
        push_v = 1'b0;
        chk("rst_rd_en", 32'(rd_en0), 32'd0);
        chk("rst_ack", 32'(ack0), 32'd0);
        chk("rst_data", data0, 32'd0);
        chk("rst_mv", 32'(mv0), 32'd0);
        chk("rst_underrun", 32'(ur0), 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);
        tick();
        chk("rst2_rd_en", 32'(rd_en0), 32'd0);
        chk("rst2_ack", 32'(ack0), 32'd0);
        rst = 1'b0; rst2 = 1'b0; req0 = 1'b0;
        tick();
        chk("first_pop", 32'(rd_en0), 32'd1);
        tick();
        chk("pop_one_cycle", 32'(rd_en0), 32'd0);
        chk("mv_not_yet", 32'(mv0), 32'd0);
        tick();
        chk("mv_latency", 32'(mv0), 32'd1);

        // Single message, addresses 0..3 back-to-back
        req0 = 1'b1; addr0 = 2'd0;
        tick();
        chk("rd_id_ack", 32'(ack0), 32'd1);
        chk("rd_id", data0, 32'h0000_0123);
        addr0 = 2'd1;
        tick();
        chk("rd_dlc", data0, 32'h0000_0008);
        addr0 = 2'd2;
        tick();
        chk("rd_dw1", data0, 32'hDEAD_BEEF);
        addr0 = 2'd3;
        tick();
        chk("rd_dw2_ack", 32'(ack0), 32'd1);
        chk("rd_dw2", data0, 32'hCAFE_F00D);
        chk("consume_mv", 32'(mv0), 32'd0);
        chk("consume_cnt", 32'(cnt0), 32'd1);
        req0 = 1'b0;
        tick();
        chk("idle_ack", 32'(ack0), 32'd0);
        chk("idle_data", data0, 32'd0);
        chk("single_pops", pops, 32'd1);

        // Repeated non-consuming reads
        push_v = 1'b1; push_d = M2;
        tick();
        push_v = 1'b0;
        wait_mv(0, "m2_mv");
        for (int i = 0; i < 5; i++) begin
            req0 = 1'b1; addr0 = 2'd1;
            tick();
            chk("rep_ack", 32'(ack0), 32'd1);
            chk("rep_dlc", data0, 32'h0000_0004);
            chk("rep_mv", 32'(mv0), 32'd1);
        end
        chk("rep_cnt", 32'(cnt0), 32'd1);
        chk("rep_pops", pops, 32'd2);
        addr0 = 2'd3;
        tick();
        chk("rep_dw2", data0, 32'h3333_4444);
        chk("rep_mv_clr", 32'(mv0), 32'd0);
        chk("rep_cnt2", 32'(cnt0), 32'd2);
        req0 = 1'b0;

        // Back-to-back messages, DW2 read as soon as msg_valid rises
        for (int k = 0; k < 3; k++) begin
            push_v = 1'b1; push_d = mb[k];
            tick();
        end
        push_v = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_mv(0, "b2b_mv");
            req0 = 1'b1; addr0 = 2'd3;
            tick();
            chk("b2b_dw2", data0, mb_dw2[k]);
            chk("b2b_mv_clr", 32'(mv0), 32'd0);
            req0 = 1'b0;
        end
        repeat (6) tick();
        chk("b2b_mv_empty", 32'(mv0), 32'd0);
        chk("b2b_cnt", 32'(cnt0), 32'd5);
        chk("b2b_pops", pops, 32'd5);
        chk("b2b_space1", pop_cyc[3] - pop_cyc[2], 32'd4);
        chk("b2b_space2", pop_cyc[4] - pop_cyc[3], 32'd4);

        // Underrun with FIFO empty
        req0 = 1'b1; addr0 = 2'd0;
        tick();
        chk("ur_ack", 32'(ack0), 32'd1);
        chk("ur_data", data0, 32'd0);
        chk("ur_flag", 32'(ur0), 32'd1);
        req0 = 1'b0;
        tick();
        tick();
        chk("ur_sticky", 32'(ur0), 32'd1);
        chk("ur_ack_low", 32'(ack0), 32'd0);

        // Counter wrap with CNT_W = 2
        for (int k = 0; k < 4; k++) begin
            wait_mv(1, "wrap_mv");
            req1 = 1'b1; addr1 = 2'd3;
            tick();
            chk("wrap_dw2", data1, 32'h0000_0099);
            req1 = 1'b0;
            if (k == 2) chk("wrap_cnt3", 32'(cnt1), 32'd3);
        end
        chk("wrap_cnt0", 32'(cnt1), 32'd0);
        chk("wrap_no_ur", 32'(ur1), 32'd0);

        // Reset mid-fetch with FIFO_RD_LAT = 3
        empty2 = 1'b0;
        tick();
        chk("l3_pop", 32'(rd_en2), 32'd1);
        req2 = 1'b1; addr2 = 2'd0;
        tick();
        chk("l3_ur_ack", 32'(ack2), 32'd1);
        chk("l3_ur", 32'(ur2), 32'd1);
        rst2 = 1'b1;
        tick();
        chk("l3_rst_ack", 32'(ack2), 32'd0);
        chk("l3_rst_ur", 32'(ur2), 32'd0);
        chk("l3_rst_rd_en", 32'(rd_en2), 32'd0);
        op2 = MR;
        tick();
        chk("l3_rst_mv", 32'(mv2), 32'd0);
        chk("l3_rst_rd_en2", 32'(rd_en2), 32'd0);
        rst2 = 1'b0; req2 = 1'b0;
        tick();
        chk("l3_refetch", 32'(rd_en2), 32'd1);
        chk("l3_stale_mv", 32'(mv2), 32'd0);
        empty2 = 1'b1; op2 = JK;
        tick();
        chk("l3_pop_pulse", 32'(rd_en2), 32'd0);
        tick();
        tick();
        chk("l3_mv_early", 32'(mv2), 32'd0);
        op2 = MX;
        tick();
        chk("l3_latency", 32'(mv2), 32'd1);
        op2 = JK;
        req2 = 1'b1; addr2 = 2'd0;
        tick();
        chk("l3_id", data2, 32'h0000_0777);
        addr2 = 2'd3;
        tick();
        chk("l3_dw2", data2, 32'h8765_4321);
        chk("l3_mv_clr", 32'(mv2), 32'd0);
        chk("l3_cnt", 32'(cnt2), 32'd1);
        req2 = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
